// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle sequencer for MIPS DIV/DIVU in the EX stage. It holds the
//   pipeline while a 32-step restoring division runs, then presents the
//   quotient (LO) and remainder (HI) until EX advances.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        DIV/DIVU present in EX (held until the instruction leaves EX)
//   is_signed    1 = DIV, 0 = DIVU; sampled with start
//   opa / opb    dividend / divisor; sampled with start
//   annul        exception flush of EX; cancels any division in progress
//   stall_ext    pipeline held by another source this cycle
//   stall_div    request to stall the pipeline up to and including EX
//   result_valid hi_out/lo_out hold the result of the current division
//   hi_out       remainder
//   lo_out       quotient
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module div_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        annul,
  input  logic        stall_ext,
  output logic        stall_div,
  output logic        result_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;       // {partial remainder, dividend/quotient}
  logic [31:0] dvs_q, dvs_d;     // |divisor|
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] trial;
  logic        ge;
  logic [63:0] step;
  logic [31:0] q_fix, r_fix;

  assign abs_a = (is_signed && opa[31]) ? -opa : opa;
  assign abs_b = (is_signed && opb[31]) ? -opb : opb;

  // Upper 33 bits of the left-shifted register are rq_q[63:31]. The partial
  // remainder is always below the divisor, so the trial difference stays
  // under 2^32 when it is non-negative: bit 32 is a clean borrow flag.
  assign trial = rq_q[63:31] - {1'b0, dvs_q};
  assign ge    = ~trial[32];
  assign step  = {(ge ? trial[31:0] : rq_q[62:31]), rq_q[30:0], ge};

  assign q_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? -step[31:0]  : step[31:0];
  assign r_fix = (sgn_q && neg_a_q)             ? -step[63:32] : step[63:32];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = (opb == '0) ? DONE : CALC;
        CALC: if (cnt_q == 6'd31) state_d = DONE;
        DONE: if (!stall_ext) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs; resetn gates stall_div so a held start cannot stall during reset
  always_comb begin
    stall_div    = 1'b0;
    result_valid = 1'b0;
    if (resetn && !annul) begin
      case (state_q)
        IDLE:    stall_div    = start;
        CALC:    stall_div    = 1'b1;
        DONE:    result_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath next-state; hi/lo load only on the transition into DONE
  always_comb begin
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (!annul) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rq_d    = {32'd0, abs_a};
            dvs_d   = abs_b;
            neg_a_d = opa[31];
            neg_b_d = opb[31];
            sgn_d   = is_signed;
            cnt_d   = '0;
            if (opb == '0) begin
              hi_d = opa;
              lo_d = '1;
            end
          end
        end
        CALC: begin
          rq_d  = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      rq_q    <= '0;
      dvs_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rq_q    <= rq_d;
      dvs_q   <= dvs_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps

module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        annul = 1'b0;
  logic        stall_ext = 1'b0;
  logic        stall_div;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .is_signed    (is_signed),
    .opa          (opa),
    .opb          (opb),
    .annul        (annul),
    .stall_ext    (stall_ext),
    .stall_div    (stall_div),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          nstall;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics via plain integer arithmetic
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  // Issue one divide, follow it to DONE, hold DONE for nstall extra cycles.
  // Returns on the last DONE cycle with start still high.
  task automatic div_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int nstall);
    logic [31:0] eq, er;
    int lat, exp_lat;
    model(s, a, b, eq, er);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; is_signed = s; opa = a; opb = b; annul = 1'b0; stall_ext = 1'b0;
    #1;
    check("stall_accept", 32'(stall_div), 32'd1);
    check("valid_accept", 32'(result_valid), 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      stall_ext = (nstall > 0);
      #1;
      if (!result_valid) check("stall_busy", 32'(stall_div), 32'd1);
    end while (!result_valid && lat < 40);
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_done", 32'(stall_div), 32'd0);
    check("hi", hi_out, er);
    check("lo", lo_out, eq);
    for (int k = 1; k <= nstall; k++) begin
      @(negedge clk);
      stall_ext = (k < nstall);
      #1;
      check("valid_held", 32'(result_valid), 32'd1);
      check("hi_held", hi_out, er);
      check("lo_held", lo_out, eq);
    end
    last_hi = er;
    last_lo = eq;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0; stall_ext = 1'b0; annul = 1'b0;
    #1;
    check("idle_valid", 32'(result_valid), 32'd0);
    check("idle_stall", 32'(stall_div), 32'd0);
    check("idle_hi", hi_out, last_hi);
    check("idle_lo", lo_out, last_lo);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_hi"}, hi_out, 32'd0);
    check({tag, "_lo"}, lo_out, 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_stall"}, 32'(stall_div), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    int sel;

    tbl[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        0};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 0};
    tbl[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       0};
    tbl[3] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        0};
    tbl[4] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1};
    tbl[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 0};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        2};
    tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0,        0};
    tbl[8] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 0};
    tbl[9] = '{1'b0, 32'd3,          32'd10,       32'd0,         32'd3,        0};

    // Reset state, before any clock edge
    #2;
    check_zero_outputs("reset");
    #5 resetn = 1'b1;   // first start lands on the first rising edge after this

    for (int i = 0; i < 10; i++) begin
      div_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].nstall);
      check("tbl_lo", last_lo, tbl[i].lo);
      check("tbl_hi", last_hi, tbl[i].hi);
      idle_cycle();
    end

    // DONE held 3 cycles by stall_ext, then a back-to-back DIVU 9/3
    div_op(1'b0, 32'd100, 32'd7, 3);
    div_op(1'b0, 32'd9, 32'd3, 0);
    check("b2b_lo", lo_out, 32'd3);
    check("b2b_hi", hi_out, 32'd0);
    idle_cycle();

    // annul at counter=10 of a running divide
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; opa = 32'd1000; opb = 32'd3;
    #1;
    check("annul_accept", 32'(stall_div), 32'd1);
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", 32'(stall_div), 32'd0);
    check("annul_valid", 32'(result_valid), 32'd0);
    idle_cycle();
    // annul beats start in IDLE
    @(negedge clk);
    start = 1'b1; annul = 1'b1;
    #1;
    check("annul_start_stall", 32'(stall_div), 32'd0);
    idle_cycle();
    // the FSM must be back in IDLE: full latency for the next divide
    div_op(1'b0, 32'd50, 32'd6, 0);
    idle_cycle();

    // reset pulsed mid-CALC
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; opa = 32'd1000; opb = 32'd3;
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(negedge clk);
    start = 1'b0;
    #1;
    check_zero_outputs("held_rst");
    #2 resetn = 1'b1;
    div_op(1'b0, 32'd8, 32'd2, 0);
    check("post_rst_lo", lo_out, 32'd4);
    check("post_rst_hi", hi_out, 32'd0);
    idle_cycle();

    // randomized divides against the reference model
    for (int i = 0; i < 40; i++) begin
      rs  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      div_op(rs, ra, rb, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL use a single clock domain, with the clock port clk and the asynchronous active-low reset port resetn.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 start  in  1  DIV/DIVU is present in EX; held high until the instruction leaves EX.
REQ-005 is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start.
REQ-006 opa  in  32  dividend (rs), sampled with start.
REQ-007 opb  in  32  divisor (rt), sampled with start.
REQ-008 annul  in  1  exception flush of EX; cancels any division in progress.
REQ-009 stall_ext  in  1  pipeline is held by another source; EX will not advance this cycle.
REQ-010 stall_div  out  1  request to stall the pipeline up to and including EX.
REQ-011 result_valid  out  1  hi_out/lo_out hold the result of the current division.
REQ-012 hi_out  out  32  remainder, written to HI by the HLwrite path.
REQ-013 lo_out  out  32  quotient, written to LO by the HLwrite path.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 In IDLE with start=1 and annul=0, the block SHALL drive stall_div=1 combinationally in that same cycle.
REQ-016 In the same IDLE cycle, the block SHALL latch |opa| and |opb| (absolute values when is_signed=1, raw values otherwise), the two sign bits and is_signed.
REQ-017 From IDLE with start=1, annul=0 and opb!=0, the FSM SHALL go to CALC and clear the 6-bit iteration counter to 0.
REQ-018 From IDLE with start=1, annul=0 and opb==0, the FSM SHALL go directly to DONE with lo_out=32'hFFFF_FFFF and hi_out=opa, with no sign fix-up.
REQ-019 CALC SHALL perform one restoring shift-subtract step per cycle on a 64-bit remainder/quotient register.
REQ-020 The step SHALL shift left by 1, compare the upper 33 bits against {1'b0,|opb|}, subtract when greater or equal, and set quotient bit 0 to the compare result.
REQ-021 CALC SHALL run exactly 32 cycles, counter 0..31, and go to DONE when counter==31; stall_div=1 throughout CALC.
REQ-022 On entry to DONE, sign fix-up SHALL apply when is_signed=1: quotient negated if the sign of opa differs from the sign of opb; remainder negated if opa was negative.
REQ-023 Results SHALL be mod 2^32, so signed 0x8000_0000 / 0xFFFF_FFFF yields lo=0x8000_0000 and hi=0.
REQ-024 In DONE, stall_div=0 and result_valid=1.
REQ-025 DONE SHALL persist while stall_ext=1 and SHALL go to IDLE when stall_ext=0.
REQ-026 start seen in DONE SHALL NOT begin a new division; this makes back-to-back divides start on the cycle after DONE exits.
REQ-027 Total latency SHALL be: start accepted in cycle T, result_valid first high in cycle T+33 (divisor nonzero) or T+1 (divisor zero).
REQ-028 annul=1 in any state SHALL force IDLE at the next edge, and in that same cycle stall_div=0 and result_valid=0.
REQ-029 hi_out/lo_out SHALL keep their last values when a division is annulled; annul takes priority over start.
REQ-030 hi_out/lo_out SHALL change only on entry to DONE.
REQ-031 stall_div SHALL be 0 in IDLE when start=0.
REQ-032 result_valid SHALL be 0 in IDLE and in CALC.

Reset
REQ-033 While resetn=0, the FSM SHALL be IDLE, counter=0, hi_out=0, lo_out=0, result_valid=0 and stall_div=0, independent of clk.
REQ-034 Reset asserted mid-CALC SHALL abandon the division with no partial result visible at the outputs.
REQ-035 After reset deassertion, the first start SHALL be accepted on the first rising clk edge.

Verification
REQ-036 DIVU 100/7, start held: stall_div high cycles T..T+32; at T+33 result_valid=1, lo=14, hi=2, stall_div=0.
REQ-037 DIV -7/2 (opa=0xFFFF_FFF9, opb=2): lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIV 0x8000_0000/0xFFFF_FFFF: lo=0x8000_0000, hi=0.
REQ-038 DIVU 5/0: result_valid at T+1, lo=0xFFFF_FFFF, hi=5, stall_div high only in cycle T.
REQ-039 annul pulsed at CALC counter=10: next cycle IDLE, stall_div=0, result_valid=0, hi/lo equal to the previous division's values.
REQ-040 stall_ext=1 for 3 cycles while in DONE: result_valid stays 1 for 4 cycles; a second DIVU 9/3 issued immediately afterwards gives lo=3, hi=0 after 33 more cycles.
REQ-041 resetn pulsed low mid-CALC: all outputs go to 0 asynchronously; a following DIVU 8/2 gives lo=4, hi=0.
